// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths, gradient type and saturation constant for the Sobel combine path
package sobel_pkg;
  localparam int TERM_W_DEF = 10;
  localparam int SUM_W = TERM_W_DEF + 3;
  localparam int MAG_W = SUM_W + 1;
  localparam logic [7:0] MAG_SAT = 8'd255;
  typedef logic signed [SUM_W-1:0] grad_t;
endpackage

// File: rtl/sobel_sum6.sv
// sobel_sum6: two-stage registered six-term signed adder with shared advance/hold
module sobel_sum6 #(
  parameter int TERM_W = sobel_pkg::TERM_W_DEF
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       adv,
  input  logic [6*TERM_W-1:0]        terms,
  output logic signed [TERM_W+2:0]   sum
);
  localparam int SW = TERM_W + 3;
  logic signed [SW-1:0] pair [3];
  logic signed [SW-1:0] pair_q [3];
  for (genvar i = 0; i < 3; i++) begin : g_pair
    assign pair[i] = SW'($signed(terms[2*i*TERM_W +: TERM_W]))
                   + SW'($signed(terms[(2*i+1)*TERM_W +: TERM_W]));
  end
  always_ff @(posedge Clk)
    if (!Rst_n) begin
      pair_q <= '{default: '0};
      sum    <= '0;
    end else if (adv) begin
      pair_q <= pair;
      sum    <= pair_q[0] + pair_q[1] + pair_q[2];
    end
endmodule

// File: rtl/sobel_grad_combine.sv
// sobel_grad_combine: sums Gx/Gy partial terms, forms saturated L1 magnitude and edge bit,
// and counts edge pixels per frame behind a 4-stage valid/ready pipeline.
module sobel_grad_combine
  import sobel_pkg::*;
#(
  parameter int TERM_W = sobel_pkg::TERM_W_DEF,
  parameter int CNT_W  = 20
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [6*TERM_W-1:0] gx_terms,
  input  logic [6*TERM_W-1:0] gy_terms,
  input  logic [7:0]          thresh,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_mag,
  output logic                out_edge,
  output logic                out_last,
  output logic [CNT_W-1:0]    frame_edges,
  output logic                frame_done
);
  localparam int SW = TERM_W + 3;
  localparam int MW = SW + 1;
  logic adv, hs;
  logic [6*TERM_W-1:0] gx_in, gy_in;
  logic signed [SW-1:0] gx, gy;
  logic signed [MW-1:0] gx_w, gy_w;
  logic [MW-1:0] ax, ay, mag;
  logic [7:0] sat;
  logic [2:0] v, l;
  logic [CNT_W-1:0] running, inc_sat;
  logic [CNT_W:0] inc;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;
  assign hs       = out_valid & out_ready;
  // idle beats carry zeros so undriven terms never reach the datapath registers
  assign gx_in = in_valid ? gx_terms : '0;
  assign gy_in = in_valid ? gy_terms : '0;
  sobel_sum6 #(.TERM_W(TERM_W)) u_gx (.Clk(Clk), .Rst_n(Rst_n), .adv(adv), .terms(gx_in), .sum(gx));
  sobel_sum6 #(.TERM_W(TERM_W)) u_gy (.Clk(Clk), .Rst_n(Rst_n), .adv(adv), .terms(gy_in), .sum(gy));
  always_comb begin
    gx_w    = MW'(gx);
    gy_w    = MW'(gy);
    ax      = gx_w < 0 ? -gx_w : gx_w;
    ay      = gy_w < 0 ? -gy_w : gy_w;
    sat     = mag > MW'(MAG_SAT) ? MAG_SAT : mag[7:0];
    inc     = {1'b0, running} + (CNT_W+1)'(out_edge);
    inc_sat = inc[CNT_W] ? '1 : inc[CNT_W-1:0];
  end
  always_ff @(posedge Clk)
    if (!Rst_n) begin
      v         <= '0;
      l         <= '0;
      mag       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_mag   <= '0;
      out_edge  <= 1'b0;
    end else if (adv) begin
      v         <= {v[1:0], in_valid};
      l         <= {l[1:0], in_valid & in_last};
      mag       <= ax + ay;
      out_valid <= v[2];
      out_last  <= l[2];
      out_mag   <= sat;
      out_edge  <= sat >= thresh;
    end
  always_ff @(posedge Clk)
    if (!Rst_n) begin
      running     <= '0;
      frame_edges <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= hs & out_last;
      if (hs) begin
        running <= out_last ? '0 : inc_sat;
        if (out_last) frame_edges <= inc_sat;
      end
    end
endmodule
